// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO (first-word-fall-through) with a sticky overflow flag
// and an idle-line detector that pulses once after a gap in received bytes.
module uart_rx_fifo #(
  parameter int c_depth    = 16,
  parameter int c_idle_lim = 400
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic [7:0]                 m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(c_depth):0]   count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  input  logic                       ovf_clr_i,
  output logic                       idle_tick_o
);

  localparam int AW = $clog2(c_depth);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(c_idle_lim) + 1;

  typedef enum logic {DISARMED = 1'b0, COUNTING = 1'b1} idle_state_t;

  logic [7:0]    r_mem [c_depth];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  idle_state_t   r_state;
  idle_state_t   w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_tick;
  logic          w_tick_nxt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CW'(c_depth));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && m_ready_i;
  // A pop in the same cycle frees the slot, so a byte arriving while full is kept.
  assign w_push  = rx_valid_i && (!w_full || w_pop);
  assign w_drop  = rx_valid_i && w_full && !w_pop;

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem[r_wptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set dominates clear so a drop is never lost.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= DISARMED;
      r_timer <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Any received byte, even a dropped one, restarts the gap timer.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_tick_nxt  = 1'b0;
    if (rx_valid_i) begin
      w_state_nxt = COUNTING;
      w_timer_nxt = '0;
    end else if (r_state == COUNTING) begin
      if (r_timer == TW'(c_idle_lim - 1)) begin
        w_state_nxt = DISARMED;
        w_timer_nxt = '0;
        w_tick_nxt  = 1'b1;
      end else begin
        w_timer_nxt = r_timer + 1'b1;
      end
    end
  end

  assign m_data_o    = r_mem[r_rptr];
  assign m_valid_o   = !w_empty;
  assign count_o     = r_count;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign overflow_o  = r_ovf;
  assign idle_tick_o = r_tick;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/drain, overflow and idle-tick timing.
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [4:0] count_o;
  logic       full_o;
  logic       empty_o;
  logic       overflow_o;
  logic       ovf_clr_i = 1'b0;
  logic       idle_tick_o;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(.c_depth(16), .c_idle_lim(400)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .overflow_o  (overflow_o),
    .ovf_clr_i   (ovf_clr_i),
    .idle_tick_o (idle_tick_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rs;
    logic       rv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       ef;
    logic       ee;
    logic       eo;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive inputs, let one rising edge sample them, then settle before checking.
  task automatic step(input logic rs, input logic rv, input logic [7:0] d,
                      input logic rdy, input logic clr);
    rst_i      = rs;
    rx_valid_i = rv;
    rx_data_i  = d;
    m_ready_i  = rdy;
    ovf_clr_i  = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic watch_tick(input string name);
    int first;
    int ticks;
    first = -1;
    ticks = 0;
    for (int k = 1; k <= 450; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (idle_tick_o) begin
        ticks++;
        if (first < 0) first = k;
      end
    end
    chk({name, "_tick_pos"}, first, 400);
    chk({name, "_tick_cnt"}, ticks, 1);
  endtask

  initial begin
    //            rs  rv  d      rdy clr ev  ed     ec     ef  ee  eo
    tbl[0] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,5'd0,1'b0,1'b1,1'b0};
    tbl[1] = '{1'b0,1'b1,8'h55,1'b0,1'b0,1'b1,8'h55,5'd1,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b1,8'h66,1'b0,1'b0,1'b1,8'h55,5'd2,1'b0,1'b0,1'b0};
    tbl[3] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,8'h66,5'd1,1'b0,1'b0,1'b0};
    tbl[4] = '{1'b0,1'b1,8'h77,1'b1,1'b0,1'b1,8'h77,5'd1,1'b0,1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00,5'd0,1'b0,1'b1,1'b0};
    tbl[6] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00,5'd0,1'b0,1'b1,1'b0};
    tbl[7] = '{1'b0,1'b1,8'h88,1'b0,1'b1,1'b1,8'h88,5'd1,1'b0,1'b0,1'b0};
    tbl[8] = '{1'b1,1'b1,8'h99,1'b1,1'b0,1'b0,8'h00,5'd0,1'b0,1'b1,1'b0};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rs, tbl[i].rv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("v%0d_valid", i), int'(m_valid_o), int'(tbl[i].ev));
      chk($sformatf("v%0d_count", i), int'(count_o), int'(tbl[i].ec));
      chk($sformatf("v%0d_full", i), int'(full_o), int'(tbl[i].ef));
      chk($sformatf("v%0d_empty", i), int'(empty_o), int'(tbl[i].ee));
      chk($sformatf("v%0d_ovf", i), int'(overflow_o), int'(tbl[i].eo));
      if (tbl[i].ev) chk($sformatf("v%0d_data", i), int'(m_data_o), int'(tbl[i].ed));
    end

    // Fill with 17 bytes: the last one is dropped.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", int'(full_o), 1);
    chk("fill_count", int'(count_o), 16);
    chk("fill_ovf", int'(overflow_o), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), int'(m_valid_o), 1);
      chk($sformatf("drain%0d_data", i), int'(m_data_o), i);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(empty_o), 1);
    chk("drain_count", int'(count_o), 0);
    chk("drain_ovf_sticky", int'(overflow_o), 1);

    // Drop coinciding with clear: set wins; clear alone then clears.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("drop_clr_ovf", int'(overflow_o), 1);
    chk("drop_clr_count", int'(count_o), 16);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow_o), 0);

    // Push and pop while full: nothing dropped, 0xAA drained last.
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullpp_count", int'(count_o), 16);
    chk("fullpp_ovf", int'(overflow_o), 0);
    chk("fullpp_head", int'(m_data_o), 8'h21);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("pp_drain%0d", i), int'(m_data_o), 8'h21 + i);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_last", int'(m_data_o), 8'hAA);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_empty", int'(empty_o), 1);

    // Reset with 5 bytes stored and overflow set; same-cycle push/pop ignored.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", int'(count_o), 5);
    chk("pre_rst_ovf", int'(overflow_o), 1);
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_valid", int'(m_valid_o), 0);
    chk("rst_ovf", int'(overflow_o), 0);
    chk("rst_tick", int'(idle_tick_o), 0);

    // Idle tick 400 cycles after a single byte, never repeated.
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    watch_tick("single");

    // Byte at timer=399 restarts the gap: no tick then, one tick 400 later.
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    idle(399);
    chk("pre_restart_tick", int'(idle_tick_o), 0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    chk("restart_no_tick", int'(idle_tick_o), 0);
    watch_tick("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter c_depth, default 16, FIFO depth in bytes, a power of two and at least 2.
REQ-002 The block SHALL have parameter c_idle_lim, default 400, the number of clocks without a received byte before an idle tick is generated; it SHALL be at least 2.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx_data_i, input, 8 bits: received byte from the UART receiver.
REQ-006 The block SHALL have port rx_valid_i, input, 1 bit: one-cycle strobe marking rx_data_i valid.
REQ-007 The block SHALL have port m_data_o, output, 8 bits: head-of-FIFO byte.
REQ-008 The block SHALL have port m_valid_o, output, 1 bit: m_data_o holds a valid byte.
REQ-009 The block SHALL have port m_ready_i, input, 1 bit: consumer accepts the byte.
REQ-010 The block SHALL have port count_o, output, clog2(c_depth)+1 bits: current occupancy.
REQ-011 The block SHALL have ports full_o and empty_o, outputs, 1 bit each: occupancy flags.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when a byte was dropped.
REQ-013 The block SHALL have port ovf_clr_i, input, 1 bit: clears overflow_o.
REQ-014 The block SHALL have port idle_tick_o, output, 1 bit: one-cycle pulse on an idle line gap.

Function
REQ-015 The FIFO SHALL be first-word-fall-through: m_data_o equals the oldest stored byte whenever m_valid_o=1, and m_valid_o SHALL equal not empty_o.
REQ-016 A pop SHALL occur on a rising edge where m_valid_o=1 and m_ready_i=1.
- m_data_o is don't-care while m_valid_o=0.
- m_ready_i while empty has no effect.
REQ-017 A write SHALL occur on an edge where rx_valid_i=1 and the FIFO is not full; the byte SHALL be visible on m_data_o (if it becomes the head) with m_valid_o=1 one cycle later; there is no same-cycle bypass.
REQ-018 A simultaneous push and pop SHALL both be performed with count_o unchanged, including when full; a byte arriving while full is then accepted and is not dropped.
REQ-019 On rx_valid_i=1 while full without a pop, the byte SHALL be discarded, stored contents SHALL be unchanged, and overflow_o SHALL be 1 from the next cycle.
REQ-020 overflow_o SHALL stay set until an edge with ovf_clr_i=1; when a drop and ovf_clr_i coincide, set SHALL win.
REQ-021 Read and write pointers SHALL wrap modulo c_depth; count_o SHALL range 0..c_depth; full_o=(count_o==c_depth) and empty_o=(count_o==0), derived from registered state.
REQ-022 The idle detector SHALL be a two-state FSM, DISARMED and COUNTING, with a timer of at least clog2(c_idle_lim)+1 bits.
REQ-023 An edge with rx_valid_i=1 SHALL clear the timer and enter COUNTING from either state, whether or not the byte was dropped.
REQ-024 In COUNTING without rx_valid_i, the timer SHALL increment each clock.
- When the timer equals c_idle_lim-1, the FSM SHALL move to DISARMED and idle_tick_o SHALL be 1 for exactly the following cycle.
- idle_tick_o therefore asserts c_idle_lim cycles after the edge that sampled the last rx_valid_i.
REQ-025 If rx_valid_i coincides with the terminal timer value, the restart SHALL win: no tick is generated.
REQ-026 idle_tick_o SHALL be generated independently of FIFO occupancy and SHALL NOT repeat until a new byte arrives.

Reset
REQ-027 While rst_i=1 at an edge, the block SHALL:
- clear pointers and count, giving count_o=0, empty_o=1, full_o=0, m_valid_o=0;
- clear overflow_o and idle_tick_o to 0;
- clear the timer to 0 and put the idle FSM in DISARMED.
REQ-028 Reset mid-operation SHALL discard all stored bytes and ignore rx_valid_i and m_ready_i in the same cycle; FIFO RAM contents need no reset.

Verification
REQ-029 Bench SHALL cover: after reset, push 0x55 with m_ready_i=0 -> next cycle m_valid_o=1, m_data_o=0x55, count_o=1, empty_o=0.
REQ-030 Bench SHALL cover: push 17 bytes 0x00..0x10 with m_ready_i=0 (c_depth=16) -> full_o=1, count_o=16, overflow_o=1; draining yields 0x00..0x0F in order, then empty_o=1.
REQ-031 Bench SHALL cover: full FIFO, rx_valid_i and pop in the same cycle with byte 0xAA -> count_o stays 16, overflow_o stays 0, 0xAA is the last byte drained.
REQ-032 Bench SHALL cover: overflow_o=1, then a drop and ovf_clr_i in the same cycle -> overflow_o=1; then ovf_clr_i alone -> overflow_o=0.
REQ-033 Bench SHALL cover: one byte, then no input (c_idle_lim=400) -> idle_tick_o high exactly one cycle, 400 cycles after the sampling edge, with no further ticks; a byte at timer=399 -> no tick, and a tick 400 cycles later.
REQ-034 Bench SHALL cover: rst_i=1 for one cycle with 5 stored bytes and overflow_o=1 -> count_o=0, m_valid_o=0, overflow_o=0, idle_tick_o=0 on the next cycle.
